hazard_irq_ctrl: RTL and testbench
==================================

// Module: hazard_irq_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage RV32 core: generates PC/IF-ID write
//  enables and IF/ID, ID/EX and EX/MEM flush strobes. Detects load-use hazards
//  and resolves taken branches from the MEM stage.
//  Sequences interrupt entry (drain, vector, ISR) and return (mret), and holds the EPC.
//  Sits beside the pipeline registers; owns no datapath except the EPC register.
// PARAMETERS
//  DRAIN_CYCLES  3             cycles of bubbles injected before vectoring (EX/MEM/WB drain)
//  IRQ_VECTOR    32'h0000_0100 ISR entry address driven on vec_pc
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-low reset (0 = reset)
//  id_rs1        in   5   rs1 of instruction in ID
//  id_rs2        in   5   rs2 of instruction in ID
//  id_pc         in   32  PC of instruction in ID
//  id_valid      in   1   ID holds a real (non-bubble) instruction
//  id_mret       in   1   instruction in ID is mret
//  ex_memread    in   1   instruction in EX is a load
//  ex_rd         in   5   destination of instruction in EX
//  mem_branch    in   1   branch control bit in MEM (from EX/MEM register)
//  mem_zero      in   1   zero flag in MEM
//  mem_target    in   32  branch target in MEM
//  irq_req       in   1   level-sensitive interrupt request
//  pc_write      out  1   PC register load enable
//  if_id_write   out  1   IF/ID register load enable
//  if_id_flush   out  1   IF/ID -> bubble
//  id_ex_flush   out  1   ID/EX control bits -> 0
//  ex_mem_flush  out  1   EX/MEM control bits -> 0
//  pc_sel        out  2   0=PC+4, 1=mem_target, 2=vec_pc, 3=epc
//  vec_pc        out  32  constant IRQ_VECTOR
//  epc           out  32  saved return PC
//  irq_ack       out  1   one-cycle pulse on vector entry
//  in_isr        out  1   ISR active; further irq_req masked
// BEHAVIOUR
//  Reset (async, reset=0): state=RUN, cnt=0, epc=0, irq_ack=0, in_isr=0.
//   Comb outputs while in reset: pc_write=if_id_write=1, all flushes 0, pc_sel=0.
//  Comb terms:
//   taken = mem_branch & mem_zero.
//   luh = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  States (2-bit): RUN, DRAIN, VECTOR, ISR.
//  RUN/ISR, priority (highest first):
//   1) taken: pc_sel=1; if_id_flush=id_ex_flush=ex_mem_flush=1; writes=1; luh ignored.
//   2) id_mret & id_valid & state==ISR: pc_sel=3; if_id_flush=1; next=RUN, in_isr<=0.
//      id_mret in RUN is a NOP for this block.
//   3) luh: pc_write=if_id_write=0; id_ex_flush=1 (one bubble, one cycle stall).
//   4) else: pc_sel=0, writes=1, no flush.
//  IRQ accept: state==RUN & irq_req & !taken & !luh & id_valid.
//   epc<=id_pc; cnt<=DRAIN_CYCLES-1; next=DRAIN.
//   That cycle: pc_write=if_id_write=0; id_ex_flush=1 (ID instruction squashed, re-executed later).
//  DRAIN: pc_write=if_id_write=0, id_ex_flush=1 every cycle; cnt decrements.
//   When cnt==0: next=VECTOR.
//   taken in DRAIN (older branch still in MEM): epc<=mem_target;
//    ex_mem_flush=1; drain continues, cnt not reloaded.
//  VECTOR (1 cycle): pc_sel=2; pc_write=1; if_id_flush=1; irq_ack=1.
//   in_isr<=1; next=ISR.
//  ISR: as RUN but irq_req ignored; no nesting.
//  Latency: irq accept -> irq_ack = DRAIN_CYCLES+1 cycles; mret -> RUN next edge.
//  irq_req dropped during DRAIN: entry still completes (no abort).
//  Reset mid-DRAIN/VECTOR: immediate return to RUN, epc cleared.
//  DRAIN_CYCLES must be >=1; cnt width = $clog2(DRAIN_CYCLES+1).
// TESTING
//  T1 luh: ex_memread=1, ex_rd=5, id_rs2=5
//     -> 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; then normal.
//  T2 x0 load: ex_rd=0=id_rs1, ex_memread=1 -> no stall.
//  T3 taken + luh same cycle -> pc_sel=1, all three flushes=1, pc_write=1.
//  T4 irq: irq_req=1, id_pc=0x40, id_valid=1 -> epc=0x40;
//     3 DRAIN cycles; VECTOR: pc_sel=2, irq_ack=1; then in_isr=1.
//  T5 branch during DRAIN: taken, mem_target=0x80 -> epc=0x80; irq_ack still at accept+4.
//  T6 in ISR: irq_req=1 ignored; id_mret=1 -> pc_sel=3 (0x40/0x80), in_isr=0;
//     async reset=0 mid-DRAIN -> state RUN, epc=0.

Source files
------------

// File: rtl/hazard_irq_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core. It generates the PC and IF/ID
// write enables and the flush strobes, handles load-use stalls and taken
// branches resolved in MEM, and sequences interrupt entry (drain, vector, ISR)
// and mret return. The EPC register is the only datapath state it owns.
module hazard_irq_ctrl #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [31:0] id_pc,
  input  logic        id_valid,
  input  logic        id_mret,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic [31:0] mem_target,
  input  logic        irq_req,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] vec_pc,
  output logic [31:0] epc,
  output logic        irq_ack,
  output logic        in_isr
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, VECTOR, ISR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   epc_nxt;
  logic          in_isr_nxt;
  logic          taken, luh;

  assign vec_pc = IRQ_VECTOR;
  assign taken  = mem_branch & mem_zero;
  // x0 never carries a real dependency, so a load to x0 must not stall.
  assign luh    = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // State, drain counter, EPC and ISR flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      cnt    <= '0;
      epc    <= '0;
      in_isr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      epc    <= epc_nxt;
      in_isr <= in_isr_nxt;
    end
  end

  // Next-state and pipeline control; outputs are held neutral while in reset.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    epc_nxt      = epc;
    in_isr_nxt   = in_isr;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel       = 2'd0;
    irq_ack      = 1'b0;
    if (reset) begin
      case (state)
        RUN, ISR: begin
          if (taken) begin
            // Branch resolved in MEM wins over everything younger.
            pc_sel       = 2'd1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (state == ISR && id_mret && id_valid) begin
            pc_sel     = 2'd3;
            if_id_flush = 1'b1;
            state_nxt  = RUN;
            in_isr_nxt = 1'b0;
          end else if (luh) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (state == RUN && irq_req && id_valid) begin
            // Squash the ID instruction; it is re-executed on return via EPC.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            epc_nxt     = id_pc;
            cnt_nxt     = CW'(DRAIN_CYCLES - 1);
            state_nxt   = DRAIN;
          end
        end
        DRAIN: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (taken) begin
            // An older branch still in MEM redirects the return point.
            epc_nxt      = mem_target;
            ex_mem_flush = 1'b1;
          end
          if (cnt == '0) state_nxt = VECTOR;
          else           cnt_nxt   = cnt - 1'b1;
        end
        VECTOR: begin
          pc_sel      = 2'd2;
          if_id_flush = 1'b1;
          irq_ack     = 1'b1;
          in_isr_nxt  = 1'b1;
          state_nxt   = ISR;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_irq_ctrl.sv
// Randomized bench for hazard_irq_ctrl. The stimulus process drives inputs on
// the falling edge and pushes the expected outputs from a behavioural model
// that tracks interrupt entry as cycles elapsed since acceptance; a separate
// monitor pops and compares a little after each falling edge.
module tb_hazard_irq_ctrl;

  localparam int          D   = 3;
  localparam logic [31:0] VEC = 32'h0000_0100;

  logic        clk, reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [31:0] id_pc, mem_target;
  logic        id_valid, id_mret, ex_memread, mem_branch, mem_zero, irq_req;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  pc_sel;
  logic [31:0] vec_pc, epc;
  logic        irq_ack, in_isr;

  hazard_irq_ctrl #(.DRAIN_CYCLES(D), .IRQ_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_pc(id_pc),
    .id_valid(id_valid), .id_mret(id_mret), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_target(mem_target),
    .irq_req(irq_req), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pc_sel(pc_sel), .vec_pc(vec_pc), .epc(epc), .irq_ack(irq_ack), .in_isr(in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, target;
    logic        valid, mret, memread, br, zero, irq;
  } stim_t;

  typedef struct {
    logic        pw, iw, fif, fex, fmem, ack, isr;
    logic [1:0]  sel;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: cycles since IRQ acceptance (-1 = not entering), ISR flag, EPC.
  int          m_since = -1;
  bit          m_isr   = 1'b0;
  logic [31:0] m_epc   = 32'd0;

  function automatic stim_t idle(input logic [31:0] pc);
    stim_t s;
    s.rst = 1'b1; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3; s.pc = pc; s.target = 32'd0;
    s.valid = 1'b1; s.mret = 1'b0; s.memread = 1'b0; s.br = 1'b0; s.zero = 1'b0; s.irq = 1'b0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   taken, luh;
    @(negedge clk);
    reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_pc = s.pc; id_valid = s.valid;
    id_mret = s.mret; ex_memread = s.memread; ex_rd = s.rd; mem_branch = s.br;
    mem_zero = s.zero; mem_target = s.target; irq_req = s.irq;
    #1;
    if (!s.rst) begin
      m_since = -1; m_isr = 1'b0; m_epc = 32'd0;
    end
    taken = s.br && s.zero;
    luh   = s.memread && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2);
    e.pw = 1; e.iw = 1; e.fif = 0; e.fex = 0; e.fmem = 0; e.ack = 0; e.sel = 2'd0;
    e.epc = m_epc; e.isr = m_isr;
    if (!s.rst) begin
      // neutral outputs, model already cleared
    end else if (m_since >= 1 && m_since <= D) begin
      e.pw = 0; e.iw = 0; e.fex = 1;
      if (taken) begin e.fmem = 1; m_epc = s.target; end
      m_since++;
    end else if (m_since == D + 1) begin
      e.sel = 2'd2; e.fif = 1; e.ack = 1;
      m_isr = 1'b1; m_since = -1;
    end else if (taken) begin
      e.sel = 2'd1; e.fif = 1; e.fex = 1; e.fmem = 1;
    end else if (m_isr && s.mret && s.valid) begin
      e.sel = 2'd3; e.fif = 1; m_isr = 1'b0;
    end else if (luh) begin
      e.pw = 0; e.iw = 0; e.fex = 1;
    end else if (!m_isr && s.irq && s.valid) begin
      e.pw = 0; e.iw = 0; e.fex = 1; m_epc = s.pc; m_since = 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_write",     {31'd0, pc_write},     {31'd0, e.pw});
        chk("if_id_write",  {31'd0, if_id_write},  {31'd0, e.iw});
        chk("if_id_flush",  {31'd0, if_id_flush},  {31'd0, e.fif});
        chk("id_ex_flush",  {31'd0, id_ex_flush},  {31'd0, e.fex});
        chk("ex_mem_flush", {31'd0, ex_mem_flush}, {31'd0, e.fmem});
        chk("pc_sel",       {30'd0, pc_sel},       {30'd0, e.sel});
        chk("irq_ack",      {31'd0, irq_ack},      {31'd0, e.ack});
        chk("in_isr",       {31'd0, in_isr},       {31'd0, e.isr});
        chk("epc",          epc,                   e.epc);
        chk("vec_pc",       vec_pc,                VEC);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0; id_rs1 = 0; id_rs2 = 0; id_pc = 0; id_valid = 0; id_mret = 0;
    ex_memread = 0; ex_rd = 0; mem_branch = 0; mem_zero = 0; mem_target = 0; irq_req = 0;

    // Reset: outputs neutral even with a taken branch and a hazard present.
    s = idle(32'h10); s.rst = 0; s.br = 1; s.zero = 1; s.memread = 1; s.rd = 1; step(s);
    s = idle(32'h10); s.rst = 0; s.irq = 1; step(s);
    step(idle(32'h14));
    // T1 load-use on rs2, then normal flow.
    s = idle(32'h18); s.memread = 1; s.rd = 5; s.rs2 = 5; step(s);
    step(idle(32'h18));
    // T2 load to x0 never stalls.
    s = idle(32'h1c); s.memread = 1; s.rd = 0; s.rs1 = 0; step(s);
    // T3 taken branch beats load-use.
    s = idle(32'h20); s.memread = 1; s.rd = 1; s.br = 1; s.zero = 1; s.target = 32'h200; step(s);
    // T4 interrupt entry from id_pc 0x40, irq dropped during drain.
    s = idle(32'h40); s.irq = 1; step(s);
    for (int i = 0; i < D + 2; i++) step(idle(32'h44));
    // T6 irq ignored inside ISR, then mret.
    s = idle(32'h104); s.irq = 1; step(s); step(s);
    s = idle(32'h108); s.mret = 1; step(s);
    step(idle(32'h40));
    // T5 taken branch during drain redirects EPC to 0x80.
    s = idle(32'h44); s.irq = 1; step(s);
    s = idle(32'h48); s.br = 1; s.zero = 1; s.target = 32'h80; step(s);
    for (int i = 0; i < D + 1; i++) step(idle(32'h4c));
    s = idle(32'h110); s.mret = 1; step(s);
    step(idle(32'h80));
    // Reset in the middle of a drain.
    s = idle(32'h60); s.irq = 1; step(s);
    step(idle(32'h64));
    s = idle(32'h64); s.rst = 0; step(s);
    step(idle(32'h64)); step(idle(32'h68));

    // Randomized traffic with narrow register ranges to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      s.rst     = ($urandom_range(0, 149) != 0);
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.pc      = {$urandom_range(0, 255), 2'b00};
      s.target  = {$urandom_range(0, 255), 2'b00};
      s.valid   = ($urandom_range(0, 3) != 0);
      s.mret    = ($urandom_range(0, 5) == 0);
      s.memread = ($urandom_range(0, 3) == 0);
      s.br      = ($urandom_range(0, 3) == 0);
      s.zero    = ($urandom_range(0, 1) == 0);
      s.irq     = ($urandom_range(0, 3) == 0);
      step(s);
    end

    @(negedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
